div8by4u_seq: RTL and testbench
===============================

DIV8BY4U_SEQ -- requirements
Module: div8by4u_seq

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: dividend  input  8  unsigned dividend; sampled with start.
REQ-006: divisor  input  4  unsigned divisor; sampled with start.
REQ-007: busy  output  1  high in CALC and DONE; low in IDLE.
REQ-008: done  output  1  one-cycle pulse; results valid while high.
REQ-009: quotient  output  8  unsigned quotient.
REQ-010: remainder  output  4  unsigned remainder.
REQ-011: div_by_zero  output  1  set when the sampled divisor was 0.

Function
REQ-012: The block SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013: In IDLE, with start=1 at edge k and divisor!=0: dividend and divisor SHALL be latched internally, the step counter SHALL be cleared to 0, and the state SHALL move to CALC.
REQ-014: In IDLE, with start=1 at edge k and divisor=0: the state SHALL move directly to DONE at edge k with quotient=8'hFF, remainder=dividend[3:0] and div_by_zero=1.
REQ-015: CALC SHALL perform one restoring-division step per edge, MSB first.
REQ-016: Each step SHALL shift the 5-bit partial remainder left by 1, shifting in the next dividend bit.
REQ-017: If the shifted partial remainder is >= {1'b0,divisor}, the step SHALL subtract the divisor and set the quotient bit to 1; otherwise the quotient bit SHALL be 0.
REQ-018: The partial remainder SHALL be 5 bits wide so that no step overflows.
REQ-019: After exactly 8 steps (edges k+1..k+8), quotient, remainder and div_by_zero=0 SHALL be registered and the state SHALL move to DONE at edge k+8.
REQ-020: done SHALL be 1 only while in DONE.
REQ-021: DONE SHALL return to IDLE on the next edge unconditionally.
REQ-022: start SHALL be ignored while busy=1, including in DONE; there is no queuing.
REQ-023: quotient, remainder and div_by_zero SHALL hold their last values until the next completion, and SHALL not change during CALC.
REQ-024: Changes on dividend and divisor after edge k SHALL not affect the result in progress.
REQ-025: Results SHALL satisfy quotient*divisor+remainder == dividend, with remainder < divisor, for every divisor != 0.

Reset
REQ-026: rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers, with no clock required.
REQ-027: An assertion of rst_n during CALC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028: After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-029: Scenario: dividend=200, divisor=7, start at edge k -> done=1 after edge k+8 only, quotient=28, remainder=4, div_by_zero=0, busy high for 9 cycles.
REQ-030: Scenario: 255/1 -> quotient=255, remainder=0. Then 15/15 -> quotient=1, remainder=0. Then 0/9 -> quotient=0, remainder=0.
REQ-031: Scenario: dividend=5, divisor=0 -> done after edge k, quotient=8'hFF, remainder=5, div_by_zero=1. The next 9/3 SHALL clear div_by_zero (quotient=3, remainder=0).
REQ-032: Scenario: start held high and operands toggled every cycle during CALC -> exactly one done pulse, result matches the operands sampled at edge k, and the next operation starts only from IDLE.
REQ-033: Scenario: rst_n pulsed low at edge k+4 of 100/3 -> all outputs 0 immediately, no done pulse; a new start of 100/3 -> quotient=33, remainder=1.
REQ-034: Scenario: exhaustive sweep of all 4096 dividend/divisor pairs -> each result SHALL be checked against REQ-025 (and REQ-014 for divisor=0), with latency checked per REQ-019.

Source files
------------

// File: rtl/div8by4u_seq.sv
// ============================================================================
// Module   : div8by4u_seq
// Purpose  : 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div8by4u_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // r_work starts as the dividend and fills with quotient bits from the right
  logic [7:0] r_work;
  logic [3:0] r_dvs;
  logic [3:0] r_prem;
  logic [2:0] r_cnt;

  logic [4:0] w_shift;
  logic       w_qbit;
  logic [3:0] w_diff;
  logic [3:0] w_rem_nxt;
  logic       w_last;

  // After a subtraction the true difference is below the divisor, so 4 bits hold it
  assign w_shift   = {r_prem, r_work[7]};
  assign w_qbit    = (w_shift >= {1'b0, r_dvs});
  assign w_diff    = w_shift[3:0] - r_dvs;
  assign w_rem_nxt = w_qbit ? w_diff : w_shift[3:0];
  assign w_last    = (r_cnt == 3'd7);

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (divisor == 4'd0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= 8'd0;
      r_dvs       <= 4'd0;
      r_prem      <= 4'd0;
      r_cnt       <= 3'd0;
      quotient    <= 8'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != 4'd0) begin
              r_work <= dividend;
              r_dvs  <= divisor;
              r_prem <= 4'd0;
              r_cnt  <= 3'd0;
            end else begin
              quotient    <= 8'hFF;
              remainder   <= dividend[3:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_work <= {r_work[6:0], w_qbit};
          r_prem <= w_rem_nxt;
          r_cnt  <= r_cnt + 3'd1;
          // Published results only change on the final step
          if (w_last) begin
            quotient    <= {r_work[6:0], w_qbit};
            remainder   <= w_rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div8by4u_seq.sv
// ============================================================================
// Module   : tb_div8by4u_seq
// Purpose  : self-checking bench for div8by4u_seq (directed vectors and full sweep)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div8by4u_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;

  // Bench-side record of the last completed result
  logic [7:0] m_q;
  logic [3:0] m_r;
  logic       m_z;

  div8by4u_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves it the same way
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit hold);
    int         lat;
    int         exp_lat;
    logic       ok_busy;
    logic       ok_hold;
    logic [7:0] eq;
    logic [7:0] er8;
    logic [3:0] er;
    if (b == 4'd0) begin
      eq      = 8'hFF;
      er      = a[3:0];
      exp_lat = 0;
    end else begin
      eq      = a / {4'd0, b};
      er8     = a % {4'd0, b};
      er      = er8[3:0];
      exp_lat = 8;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    lat     = 0;
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    while (!done && lat < 20) begin
      if (busy !== 1'b1) ok_busy = 1'b0;
      if (quotient !== m_q || remainder !== m_r || div_by_zero !== m_z) ok_hold = 1'b0;
      if (hold) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_calc", 32'(ok_busy), 32'd1);
    check("result_hold", 32'(ok_hold), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), (b == 4'd0) ? 32'd1 : 32'd0);
    m_q = eq;
    m_r = er;
    m_z = (b == 4'd0);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int nd;
    checks   = 0;
    errors   = 0;
    m_q      = 8'd0;
    m_r      = 4'd0;
    m_z      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    // Release between edges; the very next edge must accept the start
    #11;
    rst_n = 1'b1;
    run_op(8'd200, 4'd7, 1'b0);
    run_op(8'd255, 4'd1, 1'b0);
    run_op(8'd15,  4'd15, 1'b0);
    run_op(8'd0,   4'd9, 1'b0);
    run_op(8'd5,   4'd0, 1'b0);
    run_op(8'd9,   4'd3, 1'b0);

    // Start held high with operands churning during the computation
    run_op(8'd77, 4'd5, 1'b1);
    run_op(8'd9,  4'd3, 1'b0);

    // Abort 100/3 four edges into the computation
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    m_q = 8'd0;
    m_r = 4'd0;
    m_z = 1'b0;
    #2;
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    run_op(8'd100, 4'd3, 1'b0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
